// File: rtl/imc_instr_fetch_if.sv
// Purpose : bundles the instruction RAM read port and the decoder handshake.
// Latency : none (wires only).
// Backpressure: the decoder side throttles through instr_ready.
//
// Signals:
//   ram_addr/ram_cs/ram_oe/ram_we : read port driven by the fetch stage.
//   ram_rdata                     : async-read data returned by the RAM.
//   instr_valid/instr_data/instr_pc : buffer head presented to the decoder.
//   instr_ready                   : decoder accepts the head this cycle.
interface imc_instr_fetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_cs;
  logic                  ram_oe;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;

  // Fetch stage side.
  modport master (
    output ram_addr, ram_cs, ram_oe, ram_we,
    input  ram_rdata,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  // RAM + decoder side.
  modport slave (
    input  ram_addr, ram_cs, ram_oe, ram_we,
    output ram_rdata,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/imc_instr_fetch.sv
// Purpose : instruction fetch from async-read RAM into a small elastic buffer for the IMC decoder.
// Latency : start at edge k -> first word valid after edge k+1; 1 word/cycle sustained.
// Backpressure: RAM is not accessed while the buffer is full and not popping.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset.
//   start, start_addr     : begin a program (IDLE/DONE only).
//   halt_req              : stop fetching and drain (FETCH only).
//   redirect_valid/_addr  : flush and refetch from a new PC (FETCH/DRAIN only).
//   bus (master)          : RAM read port and decoder valid/ready handshake.
//   busy, done            : FETCH/DRAIN indicator; program-finished flag.
module imc_instr_fetch #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    RAM_DEPTH  = 64,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  imc_instr_fetch_if.master     bus,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] buf_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc   [FIFO_DEPTH];
  logic [IW-1:0]         wr_idx;
  logic                  pop, push, flush, push_ok, rd_en;

  assign bus.instr_valid = (count_q != '0);
  assign pop     = bus.instr_valid && bus.instr_ready;
  assign push_ok = (count_q < CW'(FIFO_DEPTH)) || pop;

  // Entry 0 is always the head, so the outputs come straight from a register
  // and keep their last value once the buffer empties.
  assign bus.instr_data = buf_data[0];
  assign bus.instr_pc   = buf_pc[0];

  assign bus.ram_addr = pc_q;
  assign bus.ram_cs   = rd_en;
  assign bus.ram_oe   = rd_en;
  assign bus.ram_we   = 1'b0;

  assign busy = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = start_addr;
        end
      end
      S_FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_addr;
        end else if (halt_req) begin
          state_d = S_DRAIN;
        end else if (push_ok) begin
          // The halt word itself has to be read to be recognised, so the
          // read strobe stays up in that cycle even though nothing is pushed.
          rd_en = 1'b1;
          if (bus.ram_rdata == HALT_WORD) begin
            state_d = S_DRAIN;
          end else begin
            push = 1'b1;
            if (pc_q == LAST_ADDR) state_d = S_DRAIN;
            else                   pc_d    = pc_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_addr;
          state_d = S_FETCH;
        end else if (count_q == CW'(pop)) begin
          // Empty now, or the last word leaves this cycle.
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With a simultaneous pop the new word lands one slot lower, after the shift.
  assign wr_idx = pop ? IW'(count_q - 1'b1) : IW'(count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (flush) begin
      // A pop in the redirect cycle is simply dropped along with the rest.
      count_q <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        if (pop && ((i + 1) < int'(count_q))) begin
          buf_data[i] <= buf_data[i+1];
          buf_pc[i]   <= buf_pc[i+1];
        end
      end
      if (push) begin
        buf_data[wr_idx] <= bus.ram_rdata;
        buf_pc[wr_idx]   <= pc_q;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule
